// File: rtl/regfile_seq.sv
// rtl/regfile_seq.sv - 3-cycle read/execute/writeback sequencer for the 8x16 regfile and ALU.
// Optional perf counters (INSTR_CNT, STALL_CNT) enabled by REGFILE_SEQ_PERF_EN.
module regfile_seq #(
  parameter int DATA_W = 16,
  parameter int AW     = 3
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [15:0]       INSTR,
  input  logic              INSTR_VALID,
  output logic              INSTR_READY,
  input  logic              RESUME,
  output logic [AW-1:0]     AA,
  output logic [AW-1:0]     BA,
  output logic [AW-1:0]     DA,
  output logic              RW,
  output logic [3:0]        FS,
  output logic              MB,
  output logic [DATA_W-1:0] IMM,
  output logic              DONE,
  output logic              ILLEGAL,
`ifdef REGFILE_SEQ_PERF_EN
  output logic [15:0]       INSTR_CNT,
  output logic [15:0]       STALL_CNT,
`endif
  output logic              HALTED
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WB, S_HALT} state_t;

  state_t              state_q, state_d;
  logic [15:0]         ir_q, ir_d;
  logic [AW-1:0]       aa_q, aa_d, ba_q, ba_d, da_q, da_d;
  logic [3:0]          fs_q, fs_d;
  logic                mb_q, mb_d;
  logic [DATA_W-1:0]   imm_q, imm_d;
  logic                rw_q, rw_d, done_q, done_d, illegal_q, illegal_d;
  logic [3:0]          op;

  assign op = ir_q[15:12];

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    aa_d      = aa_q;
    ba_d      = ba_q;
    da_d      = da_q;
    fs_d      = fs_q;
    mb_d      = mb_q;
    imm_d     = imm_q;
    rw_d      = 1'b0;
    done_d    = 1'b0;
    illegal_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (INSTR_VALID) begin
          ir_d    = INSTR;
          aa_d    = AW'(INSTR[8:6]);
          ba_d    = AW'(INSTR[5:3]);
          state_d = S_RD;
        end
      end
      // WB-cycle controls are registered on the RD->WB edge so they appear exactly in WB.
      S_RD: begin
        da_d      = AW'(ir_q[11:9]);
        fs_d      = op;
        mb_d      = (op == 4'h8) || (op == 4'h9);
        imm_d     = DATA_W'(ir_q[2:0]);
        rw_d      = (op >= 4'h1) && (op <= 4'h9);
        illegal_d = (op >= 4'hA) && (op <= 4'hE);
        done_d    = 1'b1;
        state_d   = S_WB;
      end
      S_WB: begin
        state_d = (op == 4'hF) ? S_HALT : S_IDLE;
      end
      S_HALT: begin
        if (RESUME) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Async reset clears rw_q immediately, so an aborted WB never completes its write.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      ir_q      <= '0;
      aa_q      <= '0;
      ba_q      <= '0;
      da_q      <= '0;
      fs_q      <= '0;
      mb_q      <= 1'b0;
      imm_q     <= '0;
      rw_q      <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      aa_q      <= aa_d;
      ba_q      <= ba_d;
      da_q      <= da_d;
      fs_q      <= fs_d;
      mb_q      <= mb_d;
      imm_q     <= imm_d;
      rw_q      <= rw_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
    end
  end

  assign INSTR_READY = (state_q == S_IDLE) && !RESET;
  assign HALTED      = (state_q == S_HALT);
  assign AA          = aa_q;
  assign BA          = ba_q;
  assign DA          = da_q;
  assign RW          = rw_q;
  assign FS          = fs_q;
  assign MB          = mb_q;
  assign IMM         = imm_q;
  assign DONE        = done_q;
  assign ILLEGAL     = illegal_q;

`ifdef REGFILE_SEQ_PERF_EN
  logic [15:0] instr_cnt_q, instr_cnt_d, stall_cnt_q, stall_cnt_d;

  always_comb begin
    instr_cnt_d = instr_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (done_q) instr_cnt_d = instr_cnt_q + 16'd1;
    if (((state_q == S_IDLE) && !INSTR_VALID) || (state_q == S_HALT))
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      instr_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      instr_cnt_q <= instr_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign INSTR_CNT = instr_cnt_q;
  assign STALL_CNT = stall_cnt_q;
`endif

endmodule
